// File: rtl/grid_cell_ctrl.sv
// grid_cell_ctrl
// Sequencer for the 12x12 board-state RAM write port. Three requesters share it:
// board clear (highest priority), ship placement and incoming shots. Placement
// and shot are served round-robin. Each one runs as a fixed-latency
// read-modify-write: IDLE -> RD -> CHK -> WR -> ACK.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   clear_req / clear_done     clear all valid cells to EMPTY / one-cycle completion pulse
//   place_req, place_x/y       place-ship request (level) and target cell
//   place_ack, place_ok        completion pulse; ok = cell was EMPTY and is now MYSHIP
//   shot_req, shot_x/y         shot request (level) and target cell
//   shot_ack, shot_ok          completion pulse; ok = cell status changed
//   shot_result                cell status after the shot
//   mem_addr/we/wdata          RAM write/read port, address {x, y}
//   mem_rdata                  RAM read data, valid one cycle after mem_addr
//   busy                       high whenever the sequencer is not idle
//
// Cell status: 00 EMPTY, 01 MYSHIP, 10 MISS, 11 HIT.
module grid_cell_ctrl #(
    parameter int GRID_ROWS    = 12,
    parameter int GRID_COLUMNS = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_req,
    output logic       clear_done,
    input  logic       place_req,
    input  logic [3:0] place_x,
    input  logic [3:0] place_y,
    output logic       place_ack,
    output logic       place_ok,
    input  logic       shot_req,
    input  logic [3:0] shot_x,
    input  logic [3:0] shot_y,
    output logic       shot_ack,
    output logic       shot_ok,
    output logic [1:0] shot_result,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [1:0] mem_wdata,
    input  logic [1:0] mem_rdata,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CHK  = 3'd2,
        ST_WR   = 3'd3,
        ST_ACK  = 3'd4,
        ST_CLR  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_MYSHIP = 2'b01;
    localparam logic [1:0] CELL_MISS   = 2'b10;
    localparam logic [1:0] CELL_HIT    = 2'b11;

    localparam logic [4:0] COL_LIM = 5'(GRID_COLUMNS);
    localparam logic [4:0] ROW_LIM = 5'(GRID_ROWS);
    localparam logic [3:0] X_LAST  = 4'(GRID_COLUMNS - 1);
    localparam logic [3:0] Y_LAST  = 4'(GRID_ROWS - 1);

    // Update rule for one cell: returns {write_needed, ok, new_status, reported_status}.
    function automatic logic [5:0] cell_update(input logic is_shot, input logic [1:0] cur);
        logic [5:0] r;
        r = {1'b0, 1'b0, CELL_EMPTY, cur};
        if (!is_shot) begin
            if (cur == CELL_EMPTY) begin
                r = {1'b1, 1'b1, CELL_MYSHIP, CELL_MYSHIP};
            end else begin
                r = {1'b0, 1'b0, CELL_EMPTY, cur};
            end
        end else begin
            case (cur)
                CELL_EMPTY:  r = {1'b1, 1'b1, CELL_MISS, CELL_MISS};
                CELL_MYSHIP: r = {1'b1, 1'b1, CELL_HIT, CELL_HIT};
                default:     r = {1'b0, 1'b0, CELL_EMPTY, cur};
            endcase
        end
        return r;
    endfunction

    state_t     state_q, state_d;
    logic       last_shot_q, last_shot_d;     // 1 = shot was granted last
    logic       op_shot_q, op_shot_d;         // granted operation is a shot
    logic [3:0] x_q, x_d, y_q, y_d;           // latched target cell
    logic       ok_q, ok_d;
    logic [1:0] res_q, res_d;
    logic [3:0] clr_x_q, clr_x_d, clr_y_q, clr_y_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic       mem_we_q, mem_we_d;
    logic [1:0] mem_wdata_q, mem_wdata_d;
    logic       place_ack_q, place_ack_d, place_ok_q, place_ok_d;
    logic       shot_ack_q, shot_ack_d, shot_ok_q, shot_ok_d;
    logic [1:0] shot_result_q, shot_result_d;
    logic       clear_done_q, clear_done_d;
    logic       busy_q, busy_d;

    logic       grant_shot_s;
    logic [3:0] gx_s, gy_s;
    logic       in_range_s;
    logic [5:0] upd_s;

    // Grant selection and range check for the IDLE decision.
    always_comb begin
        // On a tie the requester not served last wins.
        grant_shot_s = shot_req && !(place_req && last_shot_q);
        gx_s         = grant_shot_s ? shot_x : place_x;
        gy_s         = grant_shot_s ? shot_y : place_y;
        in_range_s   = ({1'b0, gx_s} < COL_LIM) && ({1'b0, gy_s} < ROW_LIM);
        upd_s        = cell_update(op_shot_q, mem_rdata);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        last_shot_d   = last_shot_q;
        op_shot_d     = op_shot_q;
        x_d           = x_q;
        y_d           = y_q;
        ok_d          = ok_q;
        res_d         = res_q;
        clr_x_d       = clr_x_q;
        clr_y_d       = clr_y_q;
        mem_addr_d    = mem_addr_q;
        mem_we_d      = 1'b0;
        mem_wdata_d   = CELL_EMPTY;
        place_ack_d   = 1'b0;
        place_ok_d    = 1'b0;
        shot_ack_d    = 1'b0;
        shot_ok_d     = 1'b0;
        shot_result_d = 2'b00;
        clear_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d     = ST_CLR;
                    clr_x_d     = 4'd0;
                    clr_y_d     = 4'd0;
                    mem_addr_d  = 8'h00;
                    mem_we_d    = 1'b1;
                end else if (place_req || shot_req) begin
                    last_shot_d = grant_shot_s;
                    op_shot_d   = grant_shot_s;
                    x_d         = gx_s;
                    y_d         = gy_s;
                    if (in_range_s) begin
                        state_d    = ST_RD;
                        mem_addr_d = {gx_s, gy_s};
                    end else begin
                        // Off-board cell: acknowledge with ok=0 and never touch the RAM.
                        state_d     = ST_ACK;
                        place_ack_d = !grant_shot_s;
                        shot_ack_d  = grant_shot_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                state_d = ST_CHK;
            end
            ST_CHK: begin
                state_d     = ST_WR;
                ok_d        = upd_s[4];
                res_d       = upd_s[1:0];
                mem_addr_d  = {x_q, y_q};
                mem_we_d    = upd_s[5];
                mem_wdata_d = upd_s[5] ? upd_s[3:2] : CELL_EMPTY;
            end
            ST_WR: begin
                state_d       = ST_ACK;
                place_ack_d   = !op_shot_q;
                place_ok_d    = !op_shot_q && ok_q;
                shot_ack_d    = op_shot_q;
                shot_ok_d     = op_shot_q && ok_q;
                shot_result_d = op_shot_q ? res_q : 2'b00;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            ST_CLR: begin
                // Sweep y inner, x outer; only on-board cells are ever addressed.
                if ((clr_x_q == X_LAST) && (clr_y_q == Y_LAST)) begin
                    state_d      = ST_DONE;
                    clear_done_d = 1'b1;
                    clr_x_d      = 4'd0;
                    clr_y_d      = 4'd0;
                end else if (clr_y_q == Y_LAST) begin
                    clr_x_d    = clr_x_q + 4'd1;
                    clr_y_d    = 4'd0;
                    mem_addr_d = {clr_x_q + 4'd1, 4'd0};
                    mem_we_d   = 1'b1;
                end else begin
                    clr_y_d    = clr_y_q + 4'd1;
                    mem_addr_d = {clr_x_q, clr_y_q + 4'd1};
                    mem_we_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, context and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_shot_q   <= 1'b1;
            op_shot_q     <= 1'b0;
            x_q           <= 4'd0;
            y_q           <= 4'd0;
            ok_q          <= 1'b0;
            res_q         <= 2'b00;
            clr_x_q       <= 4'd0;
            clr_y_q       <= 4'd0;
            mem_addr_q    <= 8'h00;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= 2'b00;
            place_ack_q   <= 1'b0;
            place_ok_q    <= 1'b0;
            shot_ack_q    <= 1'b0;
            shot_ok_q     <= 1'b0;
            shot_result_q <= 2'b00;
            clear_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_shot_q   <= last_shot_d;
            op_shot_q     <= op_shot_d;
            x_q           <= x_d;
            y_q           <= y_d;
            ok_q          <= ok_d;
            res_q         <= res_d;
            clr_x_q       <= clr_x_d;
            clr_y_q       <= clr_y_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            place_ack_q   <= place_ack_d;
            place_ok_q    <= place_ok_d;
            shot_ack_q    <= shot_ack_d;
            shot_ok_q     <= shot_ok_d;
            shot_result_q <= shot_result_d;
            clear_done_q  <= clear_done_d;
            busy_q        <= busy_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign place_ack   = place_ack_q;
    assign place_ok    = place_ok_q;
    assign shot_ack    = shot_ack_q;
    assign shot_ok     = shot_ok_q;
    assign shot_result = shot_result_q;
    assign clear_done  = clear_done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_grid_cell_ctrl.sv
// Testbench for grid_cell_ctrl: a RAM model on the write port, a board-level
// reference model that predicts every acknowledge (kind, ok, result, cycle,
// cumulative write count), and a monitor that pops and compares on each ack.
module tb_grid_cell_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear_req = 1'b0, clear_done;
    logic       place_req = 1'b0, place_ack, place_ok;
    logic [3:0] place_x = 4'd0, place_y = 4'd0;
    logic       shot_req = 1'b0, shot_ack, shot_ok;
    logic [3:0] shot_x = 4'd0, shot_y = 4'd0;
    logic [1:0] shot_result;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata = 2'b00;
    logic       busy;

    grid_cell_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .clear_req(clear_req), .clear_done(clear_done),
        .place_req(place_req), .place_x(place_x), .place_y(place_y),
        .place_ack(place_ack), .place_ok(place_ok),
        .shot_req(shot_req), .shot_x(shot_x), .shot_y(shot_y),
        .shot_ack(shot_ack), .shot_ok(shot_ok), .shot_result(shot_result),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Board RAM: synchronous read, read-before-write.
    logic [1:0] ram [256] = '{default: 2'b00};
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    typedef struct {
        int kind;     // 0 place, 1 shot, 2 clear
        int ok;
        int res;
        int ack_cyc;
        int cum_w;
        int waddr;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] mdl [256] = '{default: 2'b00};
    int         free_c = 0;
    int         exp_w = 0;
    bit         mdl_last_shot = 1'b1;
    int         tmo_cnt = 0;
    bit         end_req = 1'b0;

    task automatic serve(input int kind, input int x, input int y, inout int start);
        exp_t e;
        int lat;
        int a;
        e.kind = kind; e.ok = 0; e.res = 0; e.waddr = 0;
        if (kind == 2) begin
            for (int i = 0; i < 256; i++)
                if ((i / 16) < 12 && (i % 16) < 12) mdl[i] = 2'b00;
            exp_w += 144;
            lat = 145;
        end else begin
            mdl_last_shot = (kind == 1);
            if (x >= 12 || y >= 12) begin
                lat = 1;
            end else begin
                lat = 4;
                a = x * 16 + y;
                e.waddr = a;
                if (kind == 0) begin
                    if (mdl[a] == 2'b00) begin mdl[a] = 2'b01; e.ok = 1; exp_w++; end
                end else begin
                    if (mdl[a] == 2'b00) begin mdl[a] = 2'b10; e.ok = 1; exp_w++; end
                    else if (mdl[a] == 2'b01) begin mdl[a] = 2'b11; e.ok = 1; exp_w++; end
                    e.res = int'(mdl[a]);
                end
            end
        end
        e.ack_cyc = start + lat;
        e.cum_w   = exp_w;
        sb.push_back(e);
        start = start + lat + 1;
    endtask

    task automatic run_until_quiet(input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (place_ack) place_req = 1'b0;
            if (shot_ack) shot_req = 1'b0;
            if (clear_done) clear_req = 1'b0;
            done = !place_req && !shot_req && !clear_req && !busy;
            n++;
            if (!done && n >= budget) begin
                tmo_cnt++;
                place_req = 1'b0; shot_req = 1'b0; clear_req = 1'b0;
                done = 1'b1;
            end
        end
    endtask

    task automatic issue(input bit c, input bit p, input int px, input int py,
                         input bit s, input int sx, input int sy);
        int start;
        start = (cyc > free_c) ? cyc : free_c;
        if (c) serve(2, 0, 0, start);
        if (p && s) begin
            if (mdl_last_shot) begin
                serve(0, px, py, start); serve(1, sx, sy, start);
            end else begin
                serve(1, sx, sy, start); serve(0, px, py, start);
            end
        end else if (p) begin
            serve(0, px, py, start);
        end else if (s) begin
            serve(1, sx, sy, start);
        end
        free_c    = start;
        clear_req = c;
        place_req = p; place_x = 4'(px); place_y = 4'(py);
        shot_req  = s; shot_x = 4'(sx);  shot_y = 4'(sy);
        run_until_quiet(800);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   n_cmp = 0;
    int   n_bad = 0;
    int   act_w = 0;
    int   last_wa = 0;
    int   kind_act;
    int   diffs;
    exp_t mon_e;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            act_w = 0;
            check("reset_outputs",
                  int'({mem_addr, mem_we, mem_wdata, place_ack, place_ok, shot_ack,
                        shot_ok, shot_result, clear_done, busy}), 0);
        end else begin
            if (mem_we) begin
                act_w++;
                last_wa = int'(mem_addr);
                check("write_in_range", int'(mem_addr[7:4] < 4'd12 && mem_addr[3:0] < 4'd12), 1);
            end
            if (place_ack || shot_ack || clear_done) begin
                check("single_ack", int'(place_ack) + int'(shot_ack) + int'(clear_done), 1);
                check("ack_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    kind_act = place_ack ? 0 : (shot_ack ? 1 : 2);
                    check("ack_kind", kind_act, mon_e.kind);
                    check("ack_cycle", cyc, mon_e.ack_cyc);
                    check("write_count", act_w, mon_e.cum_w);
                    if (mon_e.kind == 0) check("place_ok", int'(place_ok), mon_e.ok);
                    if (mon_e.kind == 1) begin
                        check("shot_ok", int'(shot_ok), mon_e.ok);
                        check("shot_result", int'(shot_result), mon_e.res);
                    end
                    if (mon_e.kind != 2 && mon_e.ok == 1) check("write_addr", last_wa, mon_e.waddr);
                end
            end
        end
        if (end_req) begin
            check("timeouts", tmo_cnt, 0);
            check("scoreboard_empty", sb.size(), 0);
            diffs = 0;
            for (int i = 0; i < 256; i++) if (ram[i] !== mdl[i]) diffs++;
            check("board_contents", diffs, 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r, x1, y1, x2, y2;
        bit c, p, s;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, 1, 3, 5, 0, 0, 0);     // place on empty cell
        issue(0, 1, 3, 5, 0, 0, 0);     // place on occupied cell
        issue(0, 0, 0, 0, 1, 3, 5);     // shot hits ship
        issue(0, 0, 0, 0, 1, 0, 0);     // shot misses
        issue(0, 0, 0, 0, 1, 0, 0);     // repeat shot: no change
        issue(0, 0, 0, 0, 1, 12, 0);    // off-board shot
        issue(0, 1, 0, 15, 0, 0, 0);    // off-board place
        issue(0, 1, 7, 7, 1, 3, 6);     // simultaneous pair
        issue(0, 1, 8, 8, 1, 3, 7);
        issue(0, 1, 1, 1, 0, 0, 0);
        issue(0, 1, 9, 9, 1, 4, 4);     // pair after a place: shot goes first
        issue(1, 1, 2, 2, 0, 0, 0);     // clear with pending place
        issue(1, 1, 5, 5, 1, 5, 5);     // clear, then place/shot on same cell

        // Reset in the middle of a clear.
        clear_req = 1'b1;
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        clear_req = 1'b0;
        sb.delete();
        exp_w = 0;
        mdl_last_shot = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        free_c = cyc;
        issue(0, 0, 0, 0, 1, 0, 1);     // shot right after reset, partial clear state
        issue(1, 0, 0, 0, 0, 0, 0);     // restore a known board

        for (int k = 0; k < 80; k++) begin
            r  = int'($urandom_range(0, 24));
            c  = (r == 0);
            p  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            if (!c && !p && !s) p = 1'b1;
            x1 = int'($urandom_range(0, 12)); y1 = int'($urandom_range(0, 12));
            x2 = int'($urandom_range(0, 12)); y2 = int'($urandom_range(0, 12));
            issue(c, p, x1, y1, s, x2, y2);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        #1 end_req = 1'b1;
        repeat (10) @(negedge clk);
        $display("FAIL end_of_test: monitor did not finish");
        $fatal(1, "bench did not terminate");
    end

endmodule
